keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/calc_pkg.sv | 25 ++
 rtl/sync2.sv | 28 ++
 rtl/keypad_scanner.sv | 185 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the keypad front end and the downstream calculator.
//   - keycode constants: 5-bit codes; MSB=1 marks a hex digit in bits [3:0],
//     MSB=0 marks a function key, 5'h00 means "no key".
//   - scan_state_e: state encoding of the keypad scanner FSM.
package calc_pkg;

  localparam logic [4:0] NOKEY  = 5'h00;
  localparam logic [4:0] SQR    = 5'h01;
  localparam logic [4:0] CHSIGN = 5'h02;
  localparam logic [4:0] EQUALS = 5'h03;
  localparam logic [4:0] CA     = 5'h04;
  localparam logic [4:0] MULT   = 5'h09;
  localparam logic [4:0] MINUS  = 5'h0A;
  localparam logic [4:0] PLUS   = 5'h0B;
  localparam logic [4:0] CE     = 5'h0C;

  typedef enum logic [2:0] {
    SCAN     = 3'd0,
    DEBOUNCE = 3'd1,
    EMIT     = 3'd2,
    HELD     = 3'd3,
    RELEASE  = 3'd4
  } scan_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
//   clk     : destination clock
//   rst_n   : asynchronous active-low reset, loads RST_VAL into both flops
//   d [W]   : asynchronous input
//   q [W]   : synchronised output, two clocks of latency
module sync2 #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x6 matrix keypad scanner with debounce and single-key rollover.
//   clk       : system clock (5 MHz), rising edge
//   rst_n     : asynchronous active-low reset
//   row_n[4]  : row lines, active-low, asynchronous
//   col_n[6]  : column drives, active-low, exactly one low
//   keycode[5]: code of the current key, 5'h00 when no key
//   newkey    : one-clock pulse per debounced press
// Handshake: newkey is a fire-and-forget strobe with no ready; keycode is
// stable one clock before newkey rises and stays stable until the key has
// been released and the release has been debounced.
// The FSM state is visible as state_q for observation.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV  = 16,
  parameter int DB_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [5:0] col_n,
  output logic [4:0] keycode,
  output logic       newkey
);

  localparam int DW_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DB_CYCLES - 1);

  scan_state_e     state_q, state_d;
  logic [2:0]      col_q, col_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [DB_W-1:0] db_q, db_d;
  logic [1:0]      row_q, row_d;
  logic [4:0]      keycode_q, keycode_d;
  logic            newkey_q;

  logic [3:0] rows_s;
  logic [3:0] rows_low;
  logic       single_low;
  logic [1:0] row_enc;
  logic       only_latched;
  logic       latched_high;
  logic [2:0] col_next;

  sync2 #(.W(4), .RST_VAL(4'hF)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_n),
    .q     (rows_s)
  );

  // Digits 0-F sit in columns 0-3 at row*4+col, which is simply {row, col[1:0]}.
  function automatic logic [4:0] key_map(input logic [1:0] row, input logic [2:0] col);
    logic [4:0] code;
    code = NOKEY;
    if (col < 3'd4) begin
      code = {1'b1, row, col[1:0]};
    end else if (col == 3'd4) begin
      case (row)
        2'd0:    code = PLUS;
        2'd1:    code = MINUS;
        2'd2:    code = MULT;
        default: code = EQUALS;
      endcase
    end else begin
      case (row)
        2'd0:    code = SQR;
        2'd1:    code = CHSIGN;
        2'd2:    code = CE;
        default: code = CA;
      endcase
    end
    return code;
  endfunction

  assign rows_low     = ~rows_s;
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign single_low   = (rows_low != 4'd0) && ((rows_low & (rows_low - 4'd1)) == 4'd0);
  assign only_latched = (rows_s == ~(4'b0001 << row_q));
  assign latched_high = rows_s[row_q];
  assign col_next     = (col_q == 3'd5) ? 3'd0 : col_q + 3'd1;

  always_comb begin
    row_enc = 2'd3;
    case (rows_low)
      4'b0001: row_enc = 2'd0;
      4'b0010: row_enc = 2'd1;
      4'b0100: row_enc = 2'd2;
      default: row_enc = 2'd3;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    dwell_d   = dwell_q;
    db_d      = db_q;
    row_d     = row_q;
    keycode_d = keycode_q;
    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (single_low) begin
            // Column stays frozen on the candidate key while it debounces.
            row_d   = row_enc;
            db_d    = '0;
            state_d = DEBOUNCE;
          end else begin
            // No key, or several rows low (possible ghost): keep scanning.
            col_d = col_next;
          end
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end
      DEBOUNCE: begin
        if (!only_latched) begin
          state_d = SCAN;
          col_d   = col_next;
          dwell_d = '0;
        end else if (db_q == DB_LAST) begin
          keycode_d = key_map(row_q, col_q);
          state_d   = EMIT;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end
      EMIT: begin
        state_d = HELD;
      end
      HELD: begin
        // Only the latched row matters here, so other keys are ignored.
        if (latched_high) begin
          db_d    = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!latched_high) begin
          state_d = HELD;
        end else if (db_q == DB_LAST) begin
          keycode_d = NOKEY;
          state_d   = SCAN;
          col_d     = col_next;
          dwell_d   = '0;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SCAN;
      col_q     <= 3'd0;
      dwell_q   <= '0;
      db_q      <= '0;
      row_q     <= 2'd0;
      keycode_q <= NOKEY;
      newkey_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      dwell_q   <= dwell_d;
      db_q      <= db_d;
      row_q     <= row_d;
      keycode_q <= keycode_d;
      // Registered strobe: keycode is loaded on entry to EMIT, the pulse
      // follows one clock later, so keycode leads newkey by a cycle.
      newkey_q  <= (state_q == EMIT);
    end
  end

  assign col_n   = ~(6'b000001 << col_q);
  assign keycode = keycode_q;
  assign newkey  = newkey_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
  import calc_pkg::*;

  localparam int SCAN_DIV  = 4;
  localparam int DB_CYCLES = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_n;
  logic [5:0] col_n;
  logic [4:0] keycode;
  logic       newkey;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DB_CYCLES(DB_CYCLES)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .row_n   (row_n),
    .col_n   (col_n),
    .keycode (keycode),
    .newkey  (newkey)
  );

  // ---------------- keypad model ----------------
  // held[r*6+c] = key (r,c) pressed; it pulls row r low while column c is driven.
  logic [23:0] held = '0;

  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 6; c++)
        if (held[r*6+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt  = 0;
  int consec_err = 0;
  logic       nk_prev = 1'b0;
  logic [4:0] kc_prev = 5'h00;
  logic [4:0] exp_q[$];   // expected codes of pulses, in order
  logic [4:0] pre_q[$];   // keycode seen one cycle before each pulse

  always @(negedge clk) begin
    if (newkey) begin
      pulse_cnt++;
      pre_q.push_back(kc_prev);
      if (nk_prev) consec_err++;
    end
    nk_prev = newkey;
    kc_prev = keycode;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_newkey(input int budget, output int cycles, output bit found);
    found = 1'b0;
    cycles = budget;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (newkey) begin
        found = 1'b1;
        cycles = i + 1;
        break;
      end
    end
    #1;
  endtask

  task automatic wait_kc_zero(input int budget, output int cycles, output bit found);
    found = 1'b0;
    cycles = budget;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (keycode == NOKEY) begin
        found = 1'b1;
        cycles = i + 1;
        break;
      end
    end
  endtask

  task automatic get_pre(output logic [4:0] v);
    if (pre_q.size() > 0) v = pre_q.pop_front();
    else v = 5'bx;
  endtask

  task automatic get_exp(output logic [4:0] v);
    if (exp_q.size() > 0) v = exp_q.pop_front();
    else v = 5'bx;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (col_n !== 6'b111110) begin n_fail++; $display("FAIL reset_col_n: got %b want %b", col_n, 6'b111110); end
    n_checks++;
    if (keycode !== 5'h00) begin n_fail++; $display("FAIL reset_keycode: got %h want 00", keycode); end
    n_checks++;
    if (newkey !== 1'b0) begin n_fail++; $display("FAIL reset_newkey: got %b want 0", newkey); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean_press;
    int base, cyc; bit found; logic [4:0] pre, ex;
    base = pulse_cnt; pre_q.delete(); exp_q.push_back(5'h16);
    held[1*6+2] = 1'b1;
    wait_newkey(100, cyc, found);
    n_checks++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL clean_newkey_seen: got %b want 1", found); end
    n_checks++;
    if (keycode !== 5'h16) begin n_fail++; $display("FAIL clean_keycode: got %h want 16", keycode); end
    get_pre(pre); get_exp(ex);
    n_checks++;
    if (pre !== ex) begin n_fail++; $display("FAIL clean_keycode_lead: got %h want %h", pre, ex); end
    if (cyc < 40) repeat (40 - cyc) @(negedge clk);
    n_checks++;
    if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL clean_single_pulse: got %0d want 1", pulse_cnt - base); end
    n_checks++;
    if (keycode !== 5'h16) begin n_fail++; $display("FAIL clean_keycode_hold: got %h want 16", keycode); end
    held[1*6+2] = 1'b0;
    wait_kc_zero(40, cyc, found);
    // 2 sync clocks + 1 clock into RELEASE + DB_CYCLES of release debounce.
    n_checks++;
    if (cyc !== 11) begin n_fail++; $display("FAIL clean_release_time: got %0d want 11", cyc); end
    repeat (10) @(negedge clk);
    n_checks++;
    if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL clean_no_release_pulse: got %0d want 1", pulse_cnt - base); end
  endtask

  task automatic test_bounce;
    int base, cyc; bit found; logic [4:0] pre;
    base = pulse_cnt; pre_q.delete();
    for (int i = 0; i < 3; i++) begin
      held[0*6+4] = 1'b1; repeat (2) @(negedge clk);
      held[0*6+4] = 1'b0; repeat (2) @(negedge clk);
    end
    held[0*6+4] = 1'b1;
    wait_newkey(100, cyc, found);
    n_checks++;
    if (keycode !== PLUS) begin n_fail++; $display("FAIL bounce_keycode: got %h want 0b", keycode); end
    get_pre(pre);
    n_checks++;
    if (pre !== 5'h0B) begin n_fail++; $display("FAIL bounce_keycode_lead: got %h want 0b", pre); end
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      held[0*6+4] = 1'b0; repeat (2) @(negedge clk);
      held[0*6+4] = 1'b1; repeat (2) @(negedge clk);
    end
    n_checks++;
    if (keycode !== 5'h0B) begin n_fail++; $display("FAIL bounce_release_hold: got %h want 0b", keycode); end
    held[0*6+4] = 1'b0;
    wait_kc_zero(60, cyc, found);
    n_checks++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL bounce_release_done: got %b want 1", found); end
    repeat (10) @(negedge clk);
    n_checks++;
    if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL bounce_single_pulse: got %0d want 1", pulse_cnt - base); end
  endtask

  task automatic test_rollover;
    int base, cyc; bit found; logic [4:0] pre;
    base = pulse_cnt; pre_q.delete();
    held[3*6+3] = 1'b1;
    wait_newkey(100, cyc, found);
    n_checks++;
    if (keycode !== 5'h1F) begin n_fail++; $display("FAIL roll_first_keycode: got %h want 1f", keycode); end
    held[0*6+0] = 1'b1;
    repeat (30) @(negedge clk);
    n_checks++;
    if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL roll_ignored: got %0d want 1", pulse_cnt - base); end
    n_checks++;
    if (keycode !== 5'h1F) begin n_fail++; $display("FAIL roll_keycode_kept: got %h want 1f", keycode); end
    held[3*6+3] = 1'b0;
    wait_newkey(120, cyc, found);
    n_checks++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL roll_second_seen: got %b want 1", found); end
    n_checks++;
    if (keycode !== 5'h10) begin n_fail++; $display("FAIL roll_second_keycode: got %h want 10", keycode); end
    get_pre(pre); get_pre(pre);
    n_checks++;
    if (pre !== 5'h10) begin n_fail++; $display("FAIL roll_second_lead: got %h want 10", pre); end
    held[0*6+0] = 1'b0;
    wait_kc_zero(60, cyc, found);
    n_checks++;
    if (pulse_cnt - base !== 2) begin n_fail++; $display("FAIL roll_pulse_count: got %0d want 2", pulse_cnt - base); end
  endtask

  task automatic test_ghost;
    int base, bad; bit saw_wrap; logic [5:0] prev;
    base = pulse_cnt; bad = 0; saw_wrap = 1'b0;
    held[1*6+0] = 1'b1;
    held[2*6+0] = 1'b1;
    prev = col_n;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if ($countones(~col_n) != 1) bad++;
      if (prev == 6'b011111 && col_n == 6'b111110) saw_wrap = 1'b1;
      prev = col_n;
    end
    n_checks++;
    if (pulse_cnt - base !== 0) begin n_fail++; $display("FAIL ghost_no_pulse: got %0d want 0", pulse_cnt - base); end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL ghost_col_onehot: got %0d bad cycles want 0", bad); end
    n_checks++;
    if (saw_wrap !== 1'b1) begin n_fail++; $display("FAIL ghost_col_wrap: got %b want 1", saw_wrap); end
    n_checks++;
    if (keycode !== 5'h00) begin n_fail++; $display("FAIL ghost_keycode: got %h want 00", keycode); end
    held = '0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid_press;
    int base, cyc; bit found, reached; logic [4:0] pre;
    base = pulse_cnt; pre_q.delete(); reached = 1'b0;
    held[3*6+5] = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (dut.state_q == DEBOUNCE) begin reached = 1'b1; break; end
    end
    n_checks++;
    if (reached !== 1'b1) begin n_fail++; $display("FAIL rst_debounce_reached: got %b want 1", reached); end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (col_n !== 6'b111110) begin n_fail++; $display("FAIL rst_mid_col_n: got %b want 111110", col_n); end
    n_checks++;
    if (keycode !== 5'h00) begin n_fail++; $display("FAIL rst_mid_keycode: got %h want 00", keycode); end
    n_checks++;
    if (newkey !== 1'b0) begin n_fail++; $display("FAIL rst_mid_newkey: got %b want 0", newkey); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_newkey(120, cyc, found);
    n_checks++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL rst_after_seen: got %b want 1", found); end
    // Fresh scan to column 5 plus a full debounce cannot be shorter than this.
    n_checks++;
    if ((cyc >= 5*SCAN_DIV + DB_CYCLES) !== 1'b1) begin n_fail++; $display("FAIL rst_full_debounce: got %0d cycles want >= %0d", cyc, 5*SCAN_DIV + DB_CYCLES); end
    n_checks++;
    if (keycode !== CA) begin n_fail++; $display("FAIL rst_after_keycode: got %h want 04", keycode); end
    get_pre(pre);
    n_checks++;
    if (pre !== 5'h04) begin n_fail++; $display("FAIL rst_after_lead: got %h want 04", pre); end
    n_checks++;
    if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL rst_pulse_count: got %0d want 1", pulse_cnt - base); end
    held[3*6+5] = 1'b0;
    wait_kc_zero(60, cyc, found);
  endtask

  task automatic test_back_to_back;
    int base, cyc; bit found; logic [4:0] pre;
    int rs[3]; int cs[3]; logic [4:0] ex[3];
    rs = '{0, 0, 3}; cs = '{1, 2, 4}; ex = '{5'h11, 5'h12, 5'h03};
    base = pulse_cnt; pre_q.delete();
    for (int k = 0; k < 3; k++) begin
      held[rs[k]*6+cs[k]] = 1'b1;
      wait_newkey(100, cyc, found);
      n_checks++;
      if (keycode !== ex[k]) begin n_fail++; $display("FAIL seq_keycode_%0d: got %h want %h", k, keycode, ex[k]); end
      get_pre(pre);
      n_checks++;
      if (pre !== ex[k]) begin n_fail++; $display("FAIL seq_keycode_lead_%0d: got %h want %h", k, pre, ex[k]); end
      @(negedge clk);
      n_checks++;
      if (newkey !== 1'b0) begin n_fail++; $display("FAIL seq_pulse_width_%0d: got %b want 0", k, newkey); end
      repeat (5) @(negedge clk);
      held[rs[k]*6+cs[k]] = 1'b0;
      wait_kc_zero(60, cyc, found);
    end
    n_checks++;
    if (pulse_cnt - base !== 3) begin n_fail++; $display("FAIL seq_pulse_count: got %0d want 3", pulse_cnt - base); end
    n_checks++;
    if (consec_err !== 0) begin n_fail++; $display("FAIL newkey_consecutive: got %0d want 0", consec_err); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_rollover();
    test_ghost();
    test_reset_mid_press();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
